// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: ID-side fields and flush in, registered EX fields and hazard status out.
interface id_ex_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4
);
  logic [ADDR_W-1:0] RA1_ID, RA2_ID;
  logic [DATA_W-1:0] RD1_ID, RD2_ID, IMM_ID;
  logic [OP_W-1:0]   ALUOP_ID;
  logic              RegWrite_ID, MemRead_ID, MemWrite_ID, R0W_ID, IsMul_ID, Valid_ID;
  logic              Flush;

  logic [ADDR_W-1:0] RA1_EX, RA2_EX;
  logic [DATA_W-1:0] RD1_EX, RD2_EX, IMM_EX;
  logic [OP_W-1:0]   ALUOP_EX;
  logic              RegWrite_EX, MemRead_EX, MemWrite_EX, R0W_EX, IsMul_EX, Valid_EX;
  logic              Stall_IF_ID, Busy_EX;

  modport master (
    output RA1_ID, RA2_ID, RD1_ID, RD2_ID, IMM_ID, ALUOP_ID,
           RegWrite_ID, MemRead_ID, MemWrite_ID, R0W_ID, IsMul_ID, Valid_ID, Flush,
    input  RA1_EX, RA2_EX, RD1_EX, RD2_EX, IMM_EX, ALUOP_EX,
           RegWrite_EX, MemRead_EX, MemWrite_EX, R0W_EX, IsMul_EX, Valid_EX,
           Stall_IF_ID, Busy_EX
  );

  modport slave (
    input  RA1_ID, RA2_ID, RD1_ID, RD2_ID, IMM_ID, ALUOP_ID,
           RegWrite_ID, MemRead_ID, MemWrite_ID, R0W_ID, IsMul_ID, Valid_ID, Flush,
    output RA1_EX, RA2_EX, RD1_EX, RD2_EX, IMM_EX, ALUOP_EX,
           RegWrite_EX, MemRead_EX, MemWrite_EX, R0W_EX, IsMul_EX, Valid_EX,
           Stall_IF_ID, Busy_EX
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion, multi-cycle multiply hold and flush.
module id_ex_stage #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int OP_W       = 4,
  parameter int MUL_CYCLES = 3
) (
  input logic    clk,
  input logic    rst_n,
  id_ex_if.slave bus
);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MUL_BUSY = 1'b1;
  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic [3:0] CNT_INIT  = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

  logic [0:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] ra1, ra2;
  logic [DATA_W-1:0] rd1, rd2, imm;
  logic [OP_W-1:0]   aluop;
  logic              reg_write, mem_read, mem_write, r0w, is_mul, valid;
  logic              mul_hold, load_use, hold_ex, take_id;

  // The multiply retires during its last BUSY cycle (counter==0): EX reloads on that
  // same edge, so no separate completion flag is needed to block re-entry.
  always_comb begin
    mul_hold = ((state == MUL_BUSY) && (cnt != 4'd0)) ||
               ((state == IDLE) && valid && is_mul && MUL_MULTI);
    load_use = bus.Valid_ID && valid && mem_read && (ra1 != '0) &&
               ((ra1 == bus.RA1_ID) || (ra1 == bus.RA2_ID));
    hold_ex  = !bus.Flush && mul_hold;
    take_id  = !bus.Flush && !mul_hold && !load_use && bus.Valid_ID;
  end

  assign bus.Stall_IF_ID = !bus.Flush && (mul_hold || load_use);
  assign bus.Busy_EX     = (state == MUL_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (bus.Flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (mul_hold) begin
      if (state == IDLE) begin
        state <= MUL_BUSY;
        cnt   <= CNT_INIT;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else begin
      state <= IDLE;
      cnt   <= '0;
    end
  end

  // Bubble and flush both reduce to loading zeros whenever the ID fields are not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra1 <= '0; ra2 <= '0; rd1 <= '0; rd2 <= '0; imm <= '0; aluop <= '0;
      reg_write <= 1'b0; mem_read <= 1'b0; mem_write <= 1'b0;
      r0w <= 1'b0; is_mul <= 1'b0; valid <= 1'b0;
    end else if (!hold_ex) begin
      ra1       <= take_id ? bus.RA1_ID      : '0;
      ra2       <= take_id ? bus.RA2_ID      : '0;
      rd1       <= take_id ? bus.RD1_ID      : '0;
      rd2       <= take_id ? bus.RD2_ID      : '0;
      imm       <= take_id ? bus.IMM_ID      : '0;
      aluop     <= take_id ? bus.ALUOP_ID    : '0;
      reg_write <= take_id && bus.RegWrite_ID;
      mem_read  <= take_id && bus.MemRead_ID;
      mem_write <= take_id && bus.MemWrite_ID;
      r0w       <= take_id && bus.R0W_ID;
      is_mul    <= take_id && bus.IsMul_ID;
      valid     <= take_id;
    end
  end

  assign bus.RA1_EX      = ra1;
  assign bus.RA2_EX      = ra2;
  assign bus.RD1_EX      = rd1;
  assign bus.RD2_EX      = rd2;
  assign bus.IMM_EX      = imm;
  assign bus.ALUOP_EX    = aluop;
  assign bus.RegWrite_EX = reg_write;
  assign bus.MemRead_EX  = mem_read;
  assign bus.MemWrite_EX = mem_write;
  assign bus.R0W_EX      = r0w;
  assign bus.IsMul_EX    = is_mul;
  assign bus.Valid_EX    = valid;
endmodule
